// File: rtl/i2c_write_if.sv
// Bundle between the codec configuration sequencer, the I2C write master and the SDA/SCL pad cells.
// Handshake: start is a request that is taken only while busy=0 and done=0. busy rises the cycle after the take.
// done pulses for one cycle when the frame ends. A start seen while busy or during done is dropped and must be re-raised.
interface i2c_write_if #(
  parameter int DATA_BYTES = 2
);
  logic                    start;
  logic [6:0]              dev_addr;
  logic [8*DATA_BYTES-1:0] wr_data;
  logic                    sda_in;
  logic                    sda_out;
  logic                    scl_out;
  logic                    busy;
  logic                    done;
  logic                    ack_err;
  logic [2:0]              fsm_state;

  modport master (
    input  start, dev_addr, wr_data, sda_in,
    output sda_out, scl_out, busy, done, ack_err, fsm_state
  );

  modport slave (
    output start, dev_addr, wr_data, sda_in,
    input  sda_out, scl_out, busy, done, ack_err, fsm_state
  );
endinterface

// File: rtl/i2c_write_master.sv
// Single-master I2C write engine: START, address byte (write), DATA_BYTES payload bytes, STOP.
// Each START/BIT/ACK/STOP symbol is four quarters of CLK_DIV clocks; the pad drives are decoded from registers.
module i2c_write_master #(
  parameter int CLK_DIV    = 250,
  parameter int DATA_BYTES = 2
) (
  input  logic clk,
  input  logic rst,
  i2c_write_if.master bus
);
  localparam int FW  = 8 * (DATA_BYTES + 1);
  localparam int DW  = $clog2(CLK_DIV);
  localparam int BCW = (DATA_BYTES > 0) ? $clog2(DATA_BYTES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_ACK   = 3'd3,
    S_STOP  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t         state, state_nx;
  logic [DW-1:0]  div;
  logic [1:0]     qtr;
  logic [2:0]     bit_cnt;
  logic [BCW-1:0] byte_cnt;
  logic [FW-1:0]  shreg;
  logic           ack_err_q;
  logic           sda_meta, sda_sync;
  logic           tick, q_end, accept, active, last_byte;
  logic           sda_drv, scl_drv;

  assign tick      = (div == DW'(CLK_DIV - 1));
  assign q_end     = tick && (qtr == 2'd3);
  assign accept    = (state == S_IDLE) && bus.start;
  assign active    = (state == S_START) || (state == S_BIT) ||
                     (state == S_ACK)   || (state == S_STOP);
  assign last_byte = (byte_cnt == BCW'(DATA_BYTES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      div       <= '0;
      qtr       <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      shreg     <= '0;
      ack_err_q <= 1'b0;
      sda_meta  <= 1'b1;
      sda_sync  <= 1'b1;
    end else begin
      state    <= state_nx;
      sda_meta <= bus.sda_in;
      sda_sync <= sda_meta;
      if (accept) begin
        div       <= '0;
        qtr       <= '0;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        shreg     <= {bus.dev_addr, 1'b0, bus.wr_data};
        ack_err_q <= 1'b0;
      end else if (active) begin
        div <= tick ? '0 : div + DW'(1);
        if (tick) qtr <= qtr + 2'd1;
        if (q_end && (state == S_BIT)) begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + 3'd1;
        end
        // A NACK leaves byte_cnt alone; the FSM heads to STOP regardless.
        if (q_end && (state == S_ACK)) begin
          if (sda_sync) ack_err_q <= 1'b1;
          else          byte_cnt  <= byte_cnt + BCW'(1);
        end
      end else begin
        div <= '0;
        qtr <= '0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_START;
      S_START: if (q_end) state_nx = S_BIT;
      S_BIT:   if (q_end && (bit_cnt == 3'd7)) state_nx = S_ACK;
      S_ACK: begin
        if (q_end) begin
          if (sda_sync || last_byte) state_nx = S_STOP;
          else                       state_nx = S_BIT;
        end
      end
      S_STOP:  if (q_end) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Bit value is presented from Q0 and held through the SCL-high half so SDA never moves under a high SCL.
  always_comb begin
    sda_drv = 1'b1;
    scl_drv = 1'b1;
    case (state)
      S_START: begin
        sda_drv = (qtr == 2'd0);
        scl_drv = (qtr != 2'd3);
      end
      S_BIT: begin
        sda_drv = shreg[FW-1];
        scl_drv = qtr[1];
      end
      S_ACK: begin
        sda_drv = 1'b1;
        scl_drv = qtr[1];
      end
      S_STOP: begin
        sda_drv = (qtr == 2'd3);
        scl_drv = (qtr != 2'd0);
      end
      default: begin
        sda_drv = 1'b1;
        scl_drv = 1'b1;
      end
    endcase
  end

  assign bus.sda_out   = sda_drv;
  assign bus.scl_out   = scl_drv;
  assign bus.busy      = active;
  assign bus.done      = (state == S_DONE);
  assign bus.ack_err   = ack_err_q;
  assign bus.fsm_state = state;
endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: reference waveform built from the bus symbol shapes, plus an I2C slave
// that decodes bytes at SCL rise and drives ACK/NACK from a per-frame plan.
module tb_i2c_write_master;
  localparam int CLK_DIV    = 4;
  localparam int DATA_BYTES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  i2c_write_if #(.DATA_BYTES(DATA_BYTES)) bus ();

  i2c_write_master #(.CLK_DIV(CLK_DIV), .DATA_BYTES(DATA_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // ---------------- slave model / bus monitor ----------------
  logic       slave_sda = 1'b1;
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;
  logic       in_frame  = 1'b0;
  int         sl_bits   = 0;
  int         hi_changes = 0;
  logic [7:0] cur_byte  = 8'h00;
  logic       ack_plan[$];
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] wave_q[$];

  assign bus.sda_in = bus.sda_out & slave_sda;

  always @(negedge clk) begin
    if (rst) begin
      in_frame  = 1'b0;
      sl_bits   = 0;
      slave_sda = 1'b1;
    end else if (bus.scl_out && prev_scl && (bus.sda_out != prev_sda)) begin
      hi_changes++;
      if (!bus.sda_out) begin
        in_frame = 1'b1;
        sl_bits  = 0;
      end else begin
        in_frame  = 1'b0;
        slave_sda = 1'b1;
      end
    end else if (in_frame && bus.scl_out && !prev_scl) begin
      if (sl_bits < 8) begin
        cur_byte = {cur_byte[6:0], bus.sda_out};
        if (sl_bits == 7) obs_q.push_back(cur_byte);
      end
      sl_bits++;
    end else if (in_frame && !bus.scl_out && prev_scl) begin
      if (sl_bits == 8) begin
        slave_sda = (ack_plan.size() > 0) ? ack_plan.pop_front() : 1'b0;
      end else if (sl_bits == 9) begin
        slave_sda = 1'b1;
        sl_bits   = 0;
      end
    end
    prev_scl = bus.scl_out;
    prev_sda = bus.sda_out;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // ---------------- driver helpers ----------------
  task automatic add_quarter(input logic sda, input logic scl);
    repeat (CLK_DIV) wave_q.push_back({sda, scl});
  endtask

  // Runs one frame: nack[j]=1 makes the slave NACK byte j. disturb pokes start/data mid-frame,
  // poke_done raises start during the done cycle. Returns at the negedge showing done (unless poke_done).
  task automatic run_frame(input logic [6:0] addr, input logic [15:0] data, input logic [2:0] nack,
                           input bit disturb, input bit poke_done);
    logic [7:0] bytes [3];
    logic [7:0] got;
    logic [7:0] want;
    logic       exp_err;
    int         n_sent, busy_len, bad, first_bad;
    bytes[0] = {addr, 1'b0};
    bytes[1] = data[15:8];
    bytes[2] = data[7:0];
    n_sent   = 3;
    exp_err  = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (!exp_err && nack[j]) begin
        n_sent  = j + 1;
        exp_err = 1'b1;
      end
    end
    wave_q.delete();
    ack_plan.delete();
    obs_q.delete();
    exp_q.delete();
    add_quarter(1'b1, 1'b1); add_quarter(1'b0, 1'b1); add_quarter(1'b0, 1'b1); add_quarter(1'b0, 1'b0);
    for (int j = 0; j < n_sent; j++) begin
      exp_q.push_back(bytes[j]);
      ack_plan.push_back(nack[j]);
      for (int b = 7; b >= 0; b--) begin
        add_quarter(bytes[j][b], 1'b0); add_quarter(bytes[j][b], 1'b0);
        add_quarter(bytes[j][b], 1'b1); add_quarter(bytes[j][b], 1'b1);
      end
      add_quarter(1'b1, 1'b0); add_quarter(1'b1, 1'b0); add_quarter(1'b1, 1'b1); add_quarter(1'b1, 1'b1);
    end
    add_quarter(1'b0, 1'b0); add_quarter(1'b0, 1'b1); add_quarter(1'b0, 1'b1); add_quarter(1'b1, 1'b1);

    @(negedge clk);
    hi_changes   = 0;
    bus.start    = 1'b1;
    bus.dev_addr = addr;
    bus.wr_data  = data;
    @(negedge clk);
    bus.start = 1'b0;
    busy_len  = 0;
    bad       = 0;
    first_bad = -1;
    while (bus.busy === 1'b1 && busy_len < 1000) begin
      if (busy_len == 0) begin
        checks++;
        if (bus.ack_err !== 1'b0) begin
          errors++;
          $display("FAIL ack_err_clear_on_accept: got %b want 0", bus.ack_err);
        end
      end
      if (busy_len >= wave_q.size() || {bus.sda_out, bus.scl_out} !== wave_q[busy_len]) begin
        bad++;
        if (first_bad < 0) first_bad = busy_len;
      end
      if (disturb && busy_len == 37) begin
        bus.start    = 1'b1;
        bus.dev_addr = 7'($urandom_range(0, 127));
        bus.wr_data  = 16'($urandom);
      end
      if (disturb && busy_len == 38) bus.start = 1'b0;
      busy_len++;
      @(negedge clk);
    end

    checks++;
    if (busy_len != wave_q.size()) begin
      errors++;
      $display("FAIL busy_len: got %0d cycles want %0d", busy_len, wave_q.size());
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL waveform: %0d bad cycles, first at cycle %0d (got sda/scl=%b%b want %b)",
               bad, first_bad, bus.sda_out, bus.scl_out,
               (first_bad >= 0 && first_bad < wave_q.size()) ? wave_q[first_bad] : 2'bxx);
    end
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: got %b want 1", bus.done);
    end
    checks++;
    if (bus.ack_err !== exp_err) begin
      errors++;
      $display("FAIL ack_err: got %b want %b", bus.ack_err, exp_err);
    end
    checks++;
    if (hi_changes != 2) begin
      errors++;
      $display("FAIL sda_change_scl_high: got %0d events want 2 (START+STOP)", hi_changes);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL byte_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = obs_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sda_byte: got 0x%02h want 0x%02h", got, want);
      end
    end

    if (poke_done) begin
      bus.start    = 1'b1;
      bus.dev_addr = 7'($urandom_range(0, 127));
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL start_in_done_ignored: got busy=%b done=%b want 0/0", bus.busy, bus.done);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.start    = 1'b0;
    bus.dev_addr = '0;
    bus.wr_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.sda_out, bus.scl_out, bus.busy, bus.done, bus.ack_err} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_outputs: got sda,scl,busy,done,ack_err=%b want 11000",
               {bus.sda_out, bus.scl_out, bus.busy, bus.done, bus.ack_err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.sda_out, bus.scl_out, bus.busy} !== 3'b110) begin
      errors++;
      $display("FAIL idle_lines: got sda,scl,busy=%b want 110", {bus.sda_out, bus.scl_out, bus.busy});
    end
  endtask

  task automatic test_basic();
    run_frame(7'h1A, 16'h1E00, 3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b000, 1'b0, 1'b1);
    end
  endtask

  task automatic test_addr_nack();
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b001, 1'b0, 1'b1);
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b010, 1'b0, 1'b1);
  endtask

  task automatic test_last_nack();
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b100, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (bus.ack_err !== 1'b1) begin
      errors++;
      $display("FAIL ack_err_sticky: got %b want 1", bus.ack_err);
    end
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b000, 1'b0, 1'b1);
  endtask

  task automatic test_ignored();
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b000, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dev_addr = 7'($urandom_range(0, 127));
    bus.wr_data  = 16'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (209) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_before_reset: got %b want 1", bus.busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.sda_out, bus.scl_out, bus.busy, bus.done} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_mid_frame: got sda,scl,busy,done=%b want 1100",
               {bus.sda_out, bus.scl_out, bus.busy, bus.done});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b000, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b000, 1'b0, 1'b0);
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'($urandom_range(0, 7)), 1'b0, 1'b0);
    run_frame(7'($urandom_range(0, 127)), 16'($urandom), 3'b000, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_addr_nack();
    test_last_nack();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
